// File: rtl/oai22_pair_arbiter.sv
// rtl/oai22_pair_arbiter.sv - two-level round-robin arbiter over two OR-pairs of requesters
// Group choice first (A=REQ[1:0], B=REQ[3:2]), then member choice inside the winning pair.
module oai22_pair_arbiter #(
  parameter int HOLD_MAX = 15,
  parameter int CW       = 4
) (
  input  logic       CK,
  input  logic       RN,
  input  logic [3:0] REQ,
  output logic [3:0] GNT,
  output logic [1:0] GID,
  output logic       VALID,
  output logic       EXPIRE
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t        state_q;
  logic [3:0]    gnt_q;
  logic [1:0]    gid_q;
  logic          expire_q;
  logic [CW-1:0] cnt_q;
  logic          grp_last_q;
  logic [1:0]    mem_last_q;

  logic       req_a;
  logic       req_b;
  logic       win_grp;
  logic       win_mem;
  logic [1:0] win_id;

  // Prefer the group/member after the last served one; fall back to the other if idle.
  always_comb begin
    req_a   = REQ[0] | REQ[1];
    req_b   = REQ[2] | REQ[3];
    win_grp = ~grp_last_q;
    if (win_grp ? !req_b : !req_a) begin
      win_grp = grp_last_q;
    end
    win_mem = ~mem_last_q[win_grp];
    if (!REQ[{win_grp, win_mem}]) begin
      win_mem = ~win_mem;
    end
    win_id = {win_grp, win_mem};
  end

  always_ff @(posedge CK) begin
    if (!RN) begin
      state_q    <= IDLE;
      gnt_q      <= 4'b0000;
      gid_q      <= 2'd0;
      expire_q   <= 1'b0;
      cnt_q      <= '0;
      grp_last_q <= 1'b1;
      mem_last_q <= 2'b11;
    end else begin
      case (state_q)
        IDLE, RELEASE: begin
          expire_q <= 1'b0;
          if (|REQ) begin
            state_q                <= GRANT;
            gnt_q                  <= 4'b0001 << win_id;
            gid_q                  <= win_id;
            grp_last_q             <= win_id[1];
            mem_last_q[win_id[1]]  <= win_id[0];
            cnt_q                  <= CW'(1);
          end else begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
          end
        end
        GRANT: begin
          // A release that coincides with the timeout is treated as a normal release.
          if (!REQ[gid_q]) begin
            state_q <= RELEASE;
            gnt_q   <= 4'b0000;
          end else if ((HOLD_MAX != 0) && (cnt_q == CW'(HOLD_MAX))) begin
            state_q  <= RELEASE;
            gnt_q    <= 4'b0000;
            expire_q <= 1'b1;
          end else if (cnt_q != {CW{1'b1}}) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q  <= IDLE;
          gnt_q    <= 4'b0000;
          expire_q <= 1'b0;
        end
      endcase
    end
  end

  assign GNT    = gnt_q;
  assign GID    = gid_q;
  assign VALID  = |gnt_q;
  assign EXPIRE = expire_q;

endmodule

// File: tb/tb_oai22_pair_arbiter.sv
// tb/tb_oai22_pair_arbiter.sv - directed checks of oai22_pair_arbiter
// u_dut uses the 15-cycle timeout, u_dut0 runs with the timeout disabled.
module tb_oai22_pair_arbiter;

  logic       CK = 1'b0;
  logic       RN;
  logic [3:0] req;
  logic [3:0] req0;
  logic [3:0] gnt;
  logic [1:0] gid;
  logic       valid;
  logic       expire;
  logic [3:0] gnt0;
  logic [1:0] gid0;
  logic       valid0;
  logic       expire0;

  int compared = 0;
  int mismatched = 0;

  always #5 CK = ~CK;

  oai22_pair_arbiter #(.HOLD_MAX(15), .CW(4)) u_dut (
    .CK(CK), .RN(RN), .REQ(req), .GNT(gnt), .GID(gid), .VALID(valid), .EXPIRE(expire)
  );

  oai22_pair_arbiter #(.HOLD_MAX(0), .CW(4)) u_dut0 (
    .CK(CK), .RN(RN), .REQ(req0), .GNT(gnt0), .GID(gid0), .VALID(valid0), .EXPIRE(expire0)
  );

  task automatic tick;
    @(posedge CK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Call from the cycle before the granting edge; returns in the first GNT-low cycle.
  task automatic expect_tenure(input int id, input int len, input logic exp_expire);
    logic [3:0] oh;
    int hi;
    oh = 4'b0001 << id;
    tick;
    chk("tenure_gnt", gnt, oh);
    chk("tenure_gid", gid, id);
    chk("tenure_valid", valid, 1);
    hi = 1;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (gnt === oh) hi++;
      else break;
    end
    chk("tenure_len", hi, len);
    chk("tenure_gap_gnt", gnt, 0);
    chk("tenure_expire", expire, exp_expire);
  endtask

  initial begin
    RN = 1'b0;
    req = 4'b0000;
    req0 = 4'b0000;
    repeat (2) tick;
    chk("rst_gnt", gnt, 0);
    chk("rst_gid", gid, 0);
    chk("rst_valid", valid, 0);
    chk("rst_expire", expire, 0);
    RN = 1'b1;

    // No timeout: 5-cycle hold on requester 1, then a 20-cycle hold on requester 0
    req0 = 4'b0010;
    tick;
    chk("nto_gnt_rise", gnt0, 4'b0010);
    chk("nto_gid", gid0, 1);
    repeat (4) tick;
    chk("nto_gnt_hold", gnt0, 4'b0010);
    req0 = 4'b0000;
    tick;
    chk("nto_gnt_fall", gnt0, 0);
    chk("nto_expire", expire0, 0);
    tick;
    chk("nto_idle_gnt", gnt0, 0);
    req0 = 4'b0001;
    tick;
    chk("nto_long_rise", gnt0, 4'b0001);
    repeat (19) tick;
    chk("nto_long_hold", gnt0, 4'b0001);
    chk("nto_long_valid", valid0, 1);
    chk("nto_long_expire", expire0, 0);
    req0 = 4'b0000;
    tick;
    chk("nto_long_fall", gnt0, 0);
    chk("nto_long_expire2", expire0, 0);

    // All four requesting: group round-robin then member round-robin
    req = 4'b1111;
    expect_tenure(0, 15, 1'b1);
    expect_tenure(2, 15, 1'b1);
    expect_tenure(1, 15, 1'b1);
    expect_tenure(3, 15, 1'b1);
    tick;
    chk("rr5_gnt", gnt, 4'b0001);
    chk("rr5_expire", expire, 0);
    req = 4'b0000;
    tick;
    chk("rr5_rel_gnt", gnt, 0);
    chk("rr5_rel_expire", expire, 0);
    tick;

    // Release coincident with the 15th GNT-high cycle
    req = 4'b0001;
    tick;
    chk("coin_gnt", gnt, 4'b0001);
    repeat (14) tick;
    chk("coin_hold", gnt, 4'b0001);
    req = 4'b0000;
    tick;
    chk("coin_fall", gnt, 0);
    chk("coin_expire", expire, 0);
    tick;

    // Within-group alternation 0,1,0 with 3-cycle tenures
    RN = 1'b0;
    tick;
    RN = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int id;
      id = (k == 1) ? 1 : 0;
      req = 4'b0011;
      tick;
      chk("alt_gnt", gnt, 4'b0001 << id);
      chk("alt_gid", gid, id);
      repeat (2) tick;
      req[id] = 1'b0;
      tick;
      chk("alt_fall", gnt, 0);
      chk("alt_gid_kept", gid, id);
      chk("alt_expire", expire, 0);
    end
    req = 4'b0000;
    tick;
    chk("alt_idle", gnt, 0);

    // Expiry of requester 0 hands over to a late requester 3
    RN = 1'b0;
    tick;
    RN = 1'b1;
    req = 4'b0001;
    tick;
    chk("exp_gnt0", gnt, 4'b0001);
    repeat (4) tick;
    req = 4'b1001;
    repeat (10) tick;
    chk("exp_hold", gnt, 4'b0001);
    tick;
    chk("exp_fall", gnt, 0);
    chk("exp_pulse", expire, 1);
    tick;
    chk("exp_gnt3", gnt, 4'b1000);
    chk("exp_gid3", gid, 3);
    chk("exp_pulse_clr", expire, 0);
    tick;
    req = 4'b0001;
    tick;
    chk("exp_rel3", gnt, 0);
    chk("exp_rel3_expire", expire, 0);
    tick;
    chk("exp_regrant0", gnt, 4'b0001);
    chk("exp_regrant0_gid", gid, 0);

    // Reset in the middle of a tenure of requester 2
    req = 4'b0000;
    tick;
    req = 4'b0100;
    tick;
    chk("mid_gnt2", gnt, 4'b0100);
    chk("mid_gid2", gid, 2);
    RN = 1'b0;
    tick;
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_gid", gid, 0);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_expire", expire, 0);
    RN = 1'b1;
    req = 4'b1111;
    tick;
    chk("post_rst_gnt", gnt, 4'b0001);
    chk("post_rst_gid", gid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
